// File: rtl/btb_update_queue_pkg.sv
// Shared types for the BTB update queue: PC width, branch kind flags and the queued entry.
// Holds the fetch-unit queue depth and issue width used as parameter defaults.
package btb_update_queue_pkg;

    localparam int PC_PATH_WIDTH          = 32;
    localparam int INT_ISSUE_WIDTH        = 2;
    localparam int BTB_UPDATE_QUEUE_DEPTH = 8;

    typedef logic [PC_PATH_WIDTH-1:0] pc_path_t;

    typedef struct packed {
        logic is_cond_br;
        logic is_ras_push_br;
        logic is_ras_pop_br;
    } br_kind_t;

    typedef struct packed {
        pc_path_t addr;
        pc_path_t next;
        br_kind_t kind;
    } btb_update_entry_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// Branch-result lanes in, BTB update handshake and occupancy status out.
// master = pipeline/BTB side, slave = the queue.
interface btb_update_queue_if #(
    parameter int IN_WIDTH = btb_update_queue_pkg::INT_ISSUE_WIDTH,
    parameter int DEPTH    = btb_update_queue_pkg::BTB_UPDATE_QUEUE_DEPTH
);
    import btb_update_queue_pkg::*;

    logic [IN_WIDTH-1:0]           br_valid;
    logic [IN_WIDTH-1:0]           br_taken;
    pc_path_t [IN_WIDTH-1:0]       br_addr;
    pc_path_t [IN_WIDTH-1:0]       br_next;
    br_kind_t [IN_WIDTH-1:0]       br_kind;
    logic                          flush;

    logic                          upd_valid;
    logic                          upd_ready;
    pc_path_t                      upd_addr;
    pc_path_t                      upd_next;
    br_kind_t                      upd_kind;

    logic [$clog2(DEPTH):0]        count;
    logic                          full;
    logic                          empty;
    logic [15:0]                   drop_count;

    modport master (
        output br_valid, br_taken, br_addr, br_next, br_kind, flush, upd_ready,
        input  upd_valid, upd_addr, upd_next, upd_kind, count, full, empty, drop_count
    );

    modport slave (
        input  br_valid, br_taken, br_addr, br_next, br_kind, flush, upd_ready,
        output upd_valid, upd_addr, upd_next, upd_kind, count, full, empty, drop_count
    );

endinterface

// File: rtl/btb_update_queue_pointer.sv
// Head/tail/occupancy tracking for the BTB update queue: multi-push, single-pop, flush.
// free_o already credits a same-cycle pop so a full queue can still accept one push.
module btb_update_queue_pointer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH):0]   push_cnt_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH)-1:0] head_o,
    output logic [$clog2(DEPTH)-1:0] tail_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   free_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            head_d  = head_q + PW'(pop_i);
            tail_d  = tail_q + push_cnt_i[PW-1:0];
            count_d = count_q + push_cnt_i - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign free_o  = CW'(DEPTH) - count_q + CW'(pop_i);
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/btb_update_queue.sv
// Queues taken branch results for the BTB write port; drops overflow without stalling.
// Define RSD_BTB_UPDATE_MERGE_EN to coalesce same-address updates into an existing entry.
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int DEPTH    = BTB_UPDATE_QUEUE_DEPTH,
    parameter int IN_WIDTH = INT_ISSUE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    btb_update_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(IN_WIDTH + 1);

    btb_update_entry_t entries_q [DEPTH];

    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [CW-1:0]       free;
    logic                full;
    logic                empty;
    logic                pop;

    logic [CW-1:0]       n_acc;
    logic [LW-1:0]       n_drop;
    logic [IN_WIDTH-1:0] lane_we;
    logic [PW-1:0]       lane_slot  [IN_WIDTH];
    btb_update_entry_t   lane_entry [IN_WIDTH];

    logic [16:0]         drop_sum;
    logic [15:0]         drop_d;
    logic [15:0]         drop_q;

`ifdef RSD_BTB_UPDATE_MERGE_EN
    logic [IN_WIDTH-1:0] lane_new;
    logic [PW-1:0]       tail_m1;
    logic                tail_live;

    // The newest entry is only a merge target if it is not the head leaving this cycle
    assign tail_m1   = tail - PW'(1);
    assign tail_live = (count != '0) && !((count == CW'(1)) && pop);
`endif

    assign pop = !empty && bus.upd_ready;

    btb_update_queue_pointer #(.DEPTH(DEPTH)) u_pointer (
        .clk        (clk),
        .rst        (rst),
        .push_cnt_i (n_acc),
        .pop_i      (pop),
        .flush_i    (bus.flush),
        .head_o     (head),
        .tail_o     (tail),
        .count_o    (count),
        .free_o     (free),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        n_acc  = '0;
        n_drop = '0;
`ifdef RSD_BTB_UPDATE_MERGE_EN
        lane_new = '0;
`endif
        for (int i = 0; i < IN_WIDTH; i++) begin
            lane_entry[i] = '{addr: bus.br_addr[i], next: bus.br_next[i], kind: bus.br_kind[i]};
            lane_we[i]    = 1'b0;
            lane_slot[i]  = tail + PW'(n_acc);
            if (bus.br_valid[i] && bus.br_taken[i]) begin
`ifdef RSD_BTB_UPDATE_MERGE_EN
                if (tail_live && (bus.br_addr[i] == entries_q[tail_m1].addr)) begin
                    lane_we[i]   = 1'b1;
                    lane_slot[i] = tail_m1;
                end
                for (int j = 0; j < i; j++) begin
                    if (lane_new[j] && (bus.br_addr[j] == bus.br_addr[i])) begin
                        lane_we[i]   = 1'b1;
                        lane_slot[i] = lane_slot[j];
                    end
                end
`endif
                if (!lane_we[i]) begin
                    if (n_acc < free) begin
                        lane_we[i] = 1'b1;
                        n_acc      = n_acc + CW'(1);
`ifdef RSD_BTB_UPDATE_MERGE_EN
                        lane_new[i] = 1'b1;
`endif
                    end else begin
                        n_drop = n_drop + LW'(1);
                    end
                end
            end
        end
    end

    // Ascending lane order lets a later merging lane overwrite an earlier one's slot
    always_ff @(posedge clk) begin
        if (rst && !bus.flush) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (lane_we[i]) begin
                    entries_q[lane_slot[i]] <= lane_entry[i];
                end
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (!bus.flush) begin
            drop_q <= drop_d;
        end
    end

    assign bus.upd_valid  = !empty;
    assign bus.upd_addr   = entries_q[head].addr;
    assign bus.upd_next   = entries_q[head].next;
    assign bus.upd_kind   = entries_q[head].kind;
    assign bus.count      = count;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model (honours RSD_BTB_UPDATE_MERGE_EN).
module tb_btb_update_queue;
    localparam int DEPTH = 8;
    localparam int IN_W  = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] next;
        logic [2:0]  kind;
    } m_ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    m_ent_t mq[$];
    int     m_drop;

    btb_update_queue_if #(.IN_WIDTH(IN_W), .DEPTH(DEPTH)) bus ();

    btb_update_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_lane(input int i, input bit t, input logic [31:0] a,
                              input logic [31:0] n, input logic [2:0] k);
        bus.br_valid[i] = 1'b1;
        bus.br_taken[i] = t;
        bus.br_addr[i]  = a;
        bus.br_next[i]  = n;
        bus.br_kind[i]  = k;
    endtask

    task automatic clear_lanes();
        bus.br_valid = '0;
        bus.br_taken = '0;
        for (int i = 0; i < IN_W; i++) begin
            bus.br_addr[i] = '0;
            bus.br_next[i] = '0;
            bus.br_kind[i] = '0;
        end
    endtask

    // Advance the reference model with the inputs present now, then clock the DUT.
    task automatic step();
        bit     pop;
        int     n0;
        int     idx;
        m_ent_t e;
        pop = (mq.size() > 0) && bus.upd_ready;
        if (!rst) begin
            mq.delete();
            m_drop = 0;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            n0 = mq.size();
            for (int i = 0; i < IN_W; i++) begin
                if (bus.br_valid[i] && bus.br_taken[i]) begin
                    e.addr = bus.br_addr[i];
                    e.next = bus.br_next[i];
                    e.kind = bus.br_kind[i];
                    idx = -1;
`ifdef RSD_BTB_UPDATE_MERGE_EN
                    for (int k = (n0 > 0) ? n0 - 1 : 0; k < mq.size(); k++)
                        if (mq[k].addr == e.addr) idx = k;
`endif
                    if (idx >= 0) mq[idx] = e;
                    else if (mq.size() < DEPTH) mq.push_back(e);
                    else if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_lanes();
        bus.flush     = 1'b0;
        bus.upd_ready = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (int'(bus.count) !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b expected 0", bus.upd_valid); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_count); end
        drive_lane(0, 1, 32'h500, 32'h510, 3'd1);
        drive_lane(1, 1, 32'h504, 32'h514, 3'd2);
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (int'(bus.count) !== 0 || bus.upd_valid !== 1'b0) begin errors++; $display("FAIL midreset_discard: count %0d valid %b expected 0 0", bus.count, bus.upd_valid); end
        rst = 1'b1;
        clear_lanes();
        drive_lane(0, 1, 32'h600, 32'h610, 3'd4);
        step();
        checks++; if (int'(bus.count) !== 1 || bus.upd_addr !== 32'h600) begin errors++; $display("FAIL first_push_after_reset: count %0d addr %0h expected 1 600", bus.count, bus.upd_addr); end
        clear_lanes();
    endtask

    task automatic test_order();
        do_reset();
        bus.upd_ready = 1'b1;
        drive_lane(0, 1, 32'h100, 32'h180, 3'd4);
        drive_lane(1, 1, 32'h200, 32'h280, 3'd2);
        step();
        clear_lanes();
        checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== 32'h100) begin errors++; $display("FAIL order_first: valid %b addr %0h expected 1 100", bus.upd_valid, bus.upd_addr); end
        step();
        checks++; if (bus.upd_addr !== 32'h200 || bus.upd_next !== 32'h280) begin errors++; $display("FAIL order_second: addr %0h next %0h expected 200 280", bus.upd_addr, bus.upd_next); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", bus.empty); end
        // not-taken lanes must never enqueue
        drive_lane(0, 0, 32'h700, 32'h710, 3'd1);
        drive_lane(1, 0, 32'h704, 32'h714, 3'd1);
        step();
        clear_lanes();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL not_taken: empty %b expected 1", bus.empty); end
    endtask

    task automatic test_overflow_and_full_pop();
        logic [31:0] exp_q[$];
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive_lane(0, 1, 32'h1000 + 32'(c * 8), 32'h9000, 3'd1);
            if (c < 3) drive_lane(1, 1, 32'h1004 + 32'(c * 8), 32'h9000, 3'd1);
            step();
            clear_lanes();
        end
        checks++; if (int'(bus.count) !== 7) begin errors++; $display("FAIL ovf_prefill: count %0d expected 7", bus.count); end
        drive_lane(0, 1, 32'h2000, 32'h9100, 3'd2);
        drive_lane(1, 1, 32'h2004, 32'h9200, 3'd2);
        step();
        clear_lanes();
        checks++; if (int'(bus.count) !== 8 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: count %0d full %b expected 8 1", bus.count, bus.full); end
        checks++; if (bus.drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", bus.drop_count); end
        bus.upd_ready = 1'b1;
        drive_lane(0, 1, 32'h3000, 32'h9300, 3'd4);
        step();
        clear_lanes();
        checks++; if (int'(bus.count) !== 8 || bus.drop_count !== 16'd1) begin errors++; $display("FAIL full_pop: count %0d drop %0d expected 8 1", bus.count, bus.drop_count); end
        exp_q = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014, 32'h1018, 32'h2000, 32'h3000};
        for (int k = 0; k < 8; k++) begin
            checks++; if (bus.upd_valid !== 1'b1 || bus.upd_addr !== exp_q[k]) begin errors++; $display("FAIL drain_%0d: valid %b addr %0h expected 1 %0h", k, bus.upd_valid, bus.upd_addr, exp_q[k]); end
            step();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_stall_hold();
        logic [31:0] a0;
        logic [31:0] n0;
        do_reset();
        drive_lane(0, 1, 32'h800, 32'h880, 3'd1);
        step();
        drive_lane(0, 1, 32'h900, 32'h980, 3'd2);
        a0 = 32'h800;
        n0 = 32'h880;
        for (int c = 0; c < 3; c++) begin
            step();
            clear_lanes();
            checks++; if (bus.upd_addr !== a0 || bus.upd_next !== n0) begin errors++; $display("FAIL stall_hold_%0d: addr %0h next %0h expected %0h %0h", c, bus.upd_addr, bus.upd_next, a0, n0); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_lane(0, 1, 32'h4000 + 32'(c * 8), 32'h0, 3'd1);
            if (c < 2) drive_lane(1, 1, 32'h4004 + 32'(c * 8), 32'h0, 3'd1);
            step();
            clear_lanes();
        end
        checks++; if (int'(bus.count) !== 5) begin errors++; $display("FAIL flush_prefill: count %0d expected 5", bus.count); end
        bus.flush     = 1'b1;
        bus.upd_ready = 1'b1;
        drive_lane(0, 1, 32'h4100, 32'h0, 3'd1);
        drive_lane(1, 1, 32'h4104, 32'h0, 3'd1);
        step();
        bus.flush = 1'b0;
        clear_lanes();
        checks++; if (int'(bus.count) !== 0 || bus.empty !== 1'b1) begin errors++; $display("FAIL flush_clear: count %0d empty %b expected 0 1", bus.count, bus.empty); end
        checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL flush_drop: got %0d expected 0", bus.drop_count); end
        bus.upd_ready = 1'b0;
        drive_lane(1, 1, 32'h4200, 32'h4280, 3'd2);
        step();
        clear_lanes();
        checks++; if (int'(bus.count) !== 1 || bus.upd_addr !== 32'h4200) begin errors++; $display("FAIL flush_then_push: count %0d addr %0h expected 1 4200", bus.count, bus.upd_addr); end
    endtask

    task automatic test_wrap();
        int pushed;
        int popped;
        do_reset();
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 3; c++) begin
            drive_lane(0, 1, 32'h5000 + 32'(pushed * 4), 32'h0, 3'd1);
            pushed++;
            step();
        end
        bus.upd_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_lane(0, 1, 32'h5000 + 32'(pushed * 4), 32'h0, 3'd1);
            pushed++;
            popped++;
            step();
            checks++; if (bus.upd_addr !== 32'h5000 + 32'(popped * 4) || int'(bus.count) !== 3) begin errors++; $display("FAIL wrap_%0d: addr %0h count %0d expected %0h 3", c, bus.upd_addr, bus.count, 32'h5000 + 32'(popped * 4)); end
        end
        clear_lanes();
    endtask

    task automatic test_merge();
        do_reset();
        drive_lane(0, 1, 32'h300, 32'h310, 3'd4);
        step();
        drive_lane(0, 1, 32'h300, 32'h400, 3'd2);
        step();
        clear_lanes();
`ifdef RSD_BTB_UPDATE_MERGE_EN
        checks++; if (int'(bus.count) !== 1 || bus.upd_next !== 32'h400) begin errors++; $display("FAIL merge: count %0d next %0h expected 1 400", bus.count, bus.upd_next); end
`else
        checks++; if (int'(bus.count) !== 2 || bus.upd_next !== 32'h310) begin errors++; $display("FAIL merge: count %0d next %0h expected 2 310", bus.count, bus.upd_next); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < IN_W; i++) begin
                bus.br_valid[i] = ($urandom_range(0, 3) != 0);
                bus.br_taken[i] = ($urandom_range(0, 2) != 0);
                bus.br_addr[i]  = 32'h100 * 32'($urandom_range(1, 6));
                bus.br_next[i]  = $urandom;
                bus.br_kind[i]  = 3'($urandom_range(0, 7));
            end
            bus.upd_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 79) != 0);
            step();
            checks++; if (int'(bus.count) !== mq.size()) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", c, bus.count, mq.size()); end
            checks++; if (bus.upd_valid !== (mq.size() > 0) || bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rand_flags@%0d: valid %b empty %b full %b size %0d", c, bus.upd_valid, bus.empty, bus.full, mq.size()); end
            checks++; if (int'(bus.drop_count) !== m_drop) begin errors++; $display("FAIL rand_drop@%0d: got %0d expected %0d", c, bus.drop_count, m_drop); end
            if (mq.size() > 0) begin
                checks++; if (bus.upd_addr !== mq[0].addr || bus.upd_next !== mq[0].next || 3'(bus.upd_kind) !== mq[0].kind) begin errors++; $display("FAIL rand_head@%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", c, bus.upd_addr, bus.upd_next, 3'(bus.upd_kind), mq[0].addr, mq[0].next, mq[0].kind); end
            end
        end
        rst       = 1'b1;
        bus.flush = 1'b0;
        clear_lanes();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        m_drop        = 0;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.upd_ready = 1'b0;
        clear_lanes();
        #2;
        test_reset();
        test_order();
        test_overflow_and_full_pop();
        test_stall_hold();
        test_flush();
        test_wrap();
        test_merge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
